// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Dynamic branch predictor for the 5-stage core: a direct-mapped branch target
// buffer (BTB) where every entry carries a valid bit, a tag, a taken target and
// a saturating direction counter.
//
// The IF stage looks up its PC combinationally and gets a predicted next PC in
// the same cycle. The MEM stage hands back the resolved branch; the block flags
// a misprediction (with the correct next PC) combinationally and trains its
// tables on the following rising edge.
//
// Parameters
//   ADDR_W   PC / target width in bits
//   ENTRIES  number of BTB entries, power of two, >= 2
//   CTR_W    direction counter width, >= 1
//   CNT_W    width of the statistics counters
//
// Ports
//   clk              rising-edge clock
//   startin          asynchronous active-high reset
//   lk_pc            IF-stage PC to predict
//   lk_hit           valid entry with matching tag
//   lk_taken         predicted taken
//   lk_next_pc       predicted next PC
//   upd_valid        a resolved branch is presented this cycle
//   upd_pc           PC of the resolved branch
//   upd_taken        actual direction
//   upd_target       actual taken target
//   upd_pred_taken   direction that was predicted for this branch
//   upd_pred_target  next PC that was predicted for this branch
//   upd_mispredict   combinational misprediction flag
//   upd_redirect_pc  correct next PC for the resolved branch
//   flush_all        synchronous invalidate of every entry
//   stat_branches    saturating count of resolved branches
//   stat_mispred     saturating count of mispredictions
// -----------------------------------------------------------------------------
module branch_predictor #(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              startin,

    input  logic [ADDR_W-1:0] lk_pc,
    output logic              lk_hit,
    output logic              lk_taken,
    output logic [ADDR_W-1:0] lk_next_pc,

    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_target,
    output logic              upd_mispredict,
    output logic [ADDR_W-1:0] upd_redirect_pc,

    input  logic              flush_all,

    output logic [CNT_W-1:0]  stat_branches,
    output logic [CNT_W-1:0]  stat_mispred
);

    // -------------------------------------------------------------------------
    // Derived constants
    // -------------------------------------------------------------------------
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    localparam logic [CTR_W-1:0]  CTR_MAX     = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0]  CTR_ZERO    = '0;
    // Counter MSB set means "predict taken"; the two weak states straddle it.
    localparam logic [CTR_W-1:0]  CTR_WEAK_T  = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CTR_W-1:0]  CTR_WEAK_NT = CTR_WEAK_T - CTR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [ADDR_W-1:0] PC_STEP     = ADDR_W'(4);

    // -------------------------------------------------------------------------
    // Storage (flop arrays, zero read latency)
    // -------------------------------------------------------------------------
    logic [ENTRIES-1:0]             valid_q,  valid_d;
    logic [ENTRIES-1:0][CTR_W-1:0]  ctr_q,    ctr_d;
    logic [ENTRIES-1:0][TAG_W-1:0]  tag_q,    tag_d;
    logic [ENTRIES-1:0][ADDR_W-1:0] target_q, target_d;

    logic [CNT_W-1:0] stat_branches_q, stat_branches_d;
    logic [CNT_W-1:0] stat_mispred_q,  stat_mispred_d;

    // -------------------------------------------------------------------------
    // Address decomposition. The low two PC bits never take part: instructions
    // are word aligned.
    // -------------------------------------------------------------------------
    logic [IDX_W-1:0]  lk_idx;
    logic [TAG_W-1:0]  lk_tag;
    logic [IDX_W-1:0]  upd_idx;
    logic [TAG_W-1:0]  upd_tag;
    logic [ADDR_W-1:0] lk_pc_plus4;
    logic [ADDR_W-1:0] upd_pc_plus4;

    assign lk_idx       = lk_pc[IDX_W+1:2];
    assign lk_tag       = lk_pc[ADDR_W-1:IDX_W+2];
    assign upd_idx      = upd_pc[IDX_W+1:2];
    assign upd_tag      = upd_pc[ADDR_W-1:IDX_W+2];

    // Fall-through wraps at the top of the address space.
    assign lk_pc_plus4  = lk_pc + PC_STEP;
    assign upd_pc_plus4 = upd_pc + PC_STEP;

    // -------------------------------------------------------------------------
    // Lookup. Reads the registered state only, so a same-cycle update to the
    // same entry is not visible until the following cycle. Because valid_q is
    // cleared asynchronously, an asserted reset forces a miss at once.
    // -------------------------------------------------------------------------
    logic lk_hit_c;
    logic lk_taken_c;

    always_comb begin
        lk_hit_c   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        lk_taken_c = lk_hit_c && ctr_q[lk_idx][CTR_W-1];
        lk_next_pc = lk_taken_c ? target_q[lk_idx] : lk_pc_plus4;
    end

    assign lk_hit   = lk_hit_c;
    assign lk_taken = lk_taken_c;

    // -------------------------------------------------------------------------
    // Misprediction check on the resolved branch. A wrong direction is always
    // a mispredict; a correct "taken" still mispredicts if the target the
    // front end followed was stale.
    // -------------------------------------------------------------------------
    logic dir_wrong;
    logic tgt_wrong;

    always_comb begin
        dir_wrong       = (upd_pred_taken != upd_taken);
        tgt_wrong       = upd_taken && upd_pred_taken &&
                          (upd_pred_target != upd_target);
        upd_mispredict  = upd_valid && (dir_wrong || tgt_wrong);
        upd_redirect_pc = (upd_valid && upd_taken) ? upd_target : upd_pc_plus4;
    end

    // -------------------------------------------------------------------------
    // Table training. flush_all wins over a coincident update: every entry is
    // invalidated and the update trains nothing. Counters and targets are left
    // alone by the flush; with valid cleared they are unreachable, and any
    // later allocation rewrites them.
    // A not-taken branch that misses is not worth an entry, so it is ignored.
    // -------------------------------------------------------------------------
    logic upd_hit;

    always_comb begin
        valid_d  = valid_q;
        ctr_d    = ctr_q;
        tag_d    = tag_q;
        target_d = target_q;
        upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

        if (flush_all) begin
            valid_d = '0;
        end else if (upd_valid) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    if (ctr_q[upd_idx] != CTR_MAX) begin
                        ctr_d[upd_idx] = ctr_q[upd_idx] + CTR_W'(1);
                    end
                    target_d[upd_idx] = upd_target;
                end else begin
                    if (ctr_q[upd_idx] != CTR_ZERO) begin
                        ctr_d[upd_idx] = ctr_q[upd_idx] - CTR_W'(1);
                    end
                end
            end else if (upd_taken) begin
                // Allocation overwrites whatever alias lived in this slot.
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = upd_target;
                ctr_d[upd_idx]    = CTR_WEAK_T;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Statistics. Both counters stick at all-ones rather than wrapping, and
    // keep counting while a flush is in progress.
    // -------------------------------------------------------------------------
    always_comb begin
        stat_branches_d = stat_branches_q;
        stat_mispred_d  = stat_mispred_q;

        if (upd_valid && (stat_branches_q != CNT_MAX)) begin
            stat_branches_d = stat_branches_q + CNT_W'(1);
        end
        if (upd_mispredict && (stat_mispred_q != CNT_MAX)) begin
            stat_mispred_d = stat_mispred_q + CNT_W'(1);
        end
    end

    assign stat_branches = stat_branches_q;
    assign stat_mispred  = stat_mispred_q;

    // -------------------------------------------------------------------------
    // Control state with asynchronous reset: valid bits, direction counters
    // and statistics. Reset leaves every counter weakly not-taken so a fresh
    // allocation or a lone taken outcome is needed before predicting taken.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge startin) begin
        if (startin) begin
            valid_q         <= '0;
            ctr_q           <= {ENTRIES{CTR_WEAK_NT}};
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            valid_q         <= valid_d;
            ctr_q           <= ctr_d;
            stat_branches_q <= stat_branches_d;
            stat_mispred_q  <= stat_mispred_d;
        end
    end

    // -------------------------------------------------------------------------
    // Tag and target arrays carry no reset: they are only ever observed
    // through a set valid bit, and valid is always written together with them.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//
// Self-checking bench for branch_predictor. Two instances share the same
// stimulus: the default configuration and one with 4-bit statistics counters
// so that counter saturation is reachable. Expected values come from a
// behavioural model of the BTB built from per-entry arrays and integer
// counters.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

    localparam int ADDR_W  = 32;
    localparam int ENTRIES = 16;
    localparam int CTR_W   = 2;
    localparam int CNT_W   = 16;
    localparam int S_CNT_W = 4;

    localparam int unsigned CNT_MAX   = 65535;
    localparam int unsigned S_CNT_MAX = 15;

    logic              clk;
    logic              startin;
    logic [ADDR_W-1:0] lk_pc;
    logic              upd_valid;
    logic [ADDR_W-1:0] upd_pc;
    logic              upd_taken;
    logic [ADDR_W-1:0] upd_target;
    logic              upd_pred_taken;
    logic [ADDR_W-1:0] upd_pred_target;
    logic              flush_all;

    logic              lk_hit,   s_lk_hit;
    logic              lk_taken, s_lk_taken;
    logic [ADDR_W-1:0] lk_next_pc, s_lk_next_pc;
    logic              upd_mispredict, s_upd_mispredict;
    logic [ADDR_W-1:0] upd_redirect_pc, s_upd_redirect_pc;
    logic [CNT_W-1:0]  stat_branches, stat_mispred;
    logic [S_CNT_W-1:0] s_stat_branches, s_stat_mispred;

    int unsigned assertCount;
    int unsigned failCount;

    branch_predictor #(
        .ADDR_W(ADDR_W), .ENTRIES(ENTRIES), .CTR_W(CTR_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .startin(startin),
        .lk_pc(lk_pc), .lk_hit(lk_hit), .lk_taken(lk_taken), .lk_next_pc(lk_next_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .upd_mispredict(upd_mispredict),
        .upd_redirect_pc(upd_redirect_pc), .flush_all(flush_all),
        .stat_branches(stat_branches), .stat_mispred(stat_mispred)
    );

    branch_predictor #(
        .ADDR_W(ADDR_W), .ENTRIES(ENTRIES), .CTR_W(CTR_W), .CNT_W(S_CNT_W)
    ) dut_small (
        .clk(clk), .startin(startin),
        .lk_pc(lk_pc), .lk_hit(s_lk_hit), .lk_taken(s_lk_taken), .lk_next_pc(s_lk_next_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .upd_mispredict(s_upd_mispredict),
        .upd_redirect_pc(s_upd_redirect_pc), .flush_all(flush_all),
        .stat_branches(s_stat_branches), .stat_mispred(s_stat_mispred)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Behavioural model: one record per slot, counters as plain integers.
    // -------------------------------------------------------------------------
    bit          m_valid  [ENTRIES];
    int unsigned m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_ctr    [ENTRIES];
    int unsigned m_branches;
    int unsigned m_mispred;

    function automatic int slotOf(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic int unsigned tagOf(input logic [31:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    function automatic logic [31:0] satCount(input int unsigned v, input int unsigned maxVal);
        return (v > maxVal) ? maxVal : v;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = (2 ** (CTR_W - 1)) - 1;
        end
        m_branches = 0;
        m_mispred  = 0;
    endtask

    task automatic modelLookup(input logic [31:0] pc, output bit hit, output bit taken,
                               output logic [31:0] nextPc);
        int s;
        s      = slotOf(pc);
        hit    = m_valid[s] && (m_tag[s] == tagOf(pc));
        taken  = hit && (m_ctr[s] >= 2 ** (CTR_W - 1));
        nextPc = taken ? m_target[s] : pc + 32'd4;
    endtask

    task automatic modelUpdate(input bit uValid, input logic [31:0] uPc, input bit uTaken,
                               input logic [31:0] uTarget, input bit mis, input bit flush);
        int s;
        bit hit;
        s   = slotOf(uPc);
        hit = m_valid[s] && (m_tag[s] == tagOf(uPc));
        if (uValid) begin
            m_branches++;
            if (mis) m_mispred++;
        end
        if (flush) begin
            for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
        end else if (uValid) begin
            if (hit && uTaken) begin
                if (m_ctr[s] < 2 ** CTR_W - 1) m_ctr[s]++;
                m_target[s] = uTarget;
            end else if (hit) begin
                if (m_ctr[s] > 0) m_ctr[s]--;
            end else if (uTaken) begin
                m_valid[s]  = 1'b1;
                m_tag[s]    = tagOf(uPc);
                m_target[s] = uTarget;
                m_ctr[s]    = 2 ** (CTR_W - 1);
            end
        end
    endtask

    // -------------------------------------------------------------------------
    // Single comparison point: counts and reports.
    // -------------------------------------------------------------------------
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // One cycle: drive at the falling edge, check all outputs against the
    // model before the rising edge, then advance the model across that edge.
    // Returns 1 time unit after the rising edge.
    // -------------------------------------------------------------------------
    task automatic applyStimulus(input logic [31:0] lkPc, input bit uValid,
                                 input logic [31:0] uPc, input bit uTaken,
                                 input logic [31:0] uTarget, input bit pTaken,
                                 input logic [31:0] pTarget, input bit flush);
        bit          eHit, eTaken, eMis;
        logic [31:0] eNext, eRedir;
        @(negedge clk);
        lk_pc           = lkPc;
        upd_valid       = uValid;
        upd_pc          = uPc;
        upd_taken       = uTaken;
        upd_target      = uTarget;
        upd_pred_taken  = pTaken;
        upd_pred_target = pTarget;
        flush_all       = flush;
        modelLookup(lkPc, eHit, eTaken, eNext);
        eMis  = uValid && ((pTaken != uTaken) || (uTaken && pTaken && (pTarget != uTarget)));
        eRedir = (uValid && uTaken) ? uTarget : uPc + 32'd4;
        #2;
        checkOutput("lk_hit",            32'(lk_hit),          32'(eHit));
        checkOutput("lk_taken",          32'(lk_taken),        32'(eTaken));
        checkOutput("lk_next_pc",        lk_next_pc,           eNext);
        checkOutput("upd_mispredict",    32'(upd_mispredict),  32'(eMis));
        checkOutput("upd_redirect_pc",   upd_redirect_pc,      eRedir);
        checkOutput("stat_branches",     32'(stat_branches),   satCount(m_branches, CNT_MAX));
        checkOutput("stat_mispred",      32'(stat_mispred),    satCount(m_mispred, CNT_MAX));
        checkOutput("small_lk_next_pc",  s_lk_next_pc,         eNext);
        checkOutput("small_lk_hit",      32'(s_lk_hit),        32'(eHit));
        checkOutput("small_lk_taken",    32'(s_lk_taken),      32'(eTaken));
        checkOutput("small_mispredict",  32'(s_upd_mispredict), 32'(eMis));
        checkOutput("small_redirect_pc", s_upd_redirect_pc,    eRedir);
        checkOutput("small_branches",    32'(s_stat_branches), satCount(m_branches, S_CNT_MAX));
        checkOutput("small_mispred",     32'(s_stat_mispred),  satCount(m_mispred, S_CNT_MAX));
        @(posedge clk);
        modelUpdate(uValid, uPc, uTaken, uTarget, eMis, flush);
        #1;
    endtask

    function automatic logic [31:0] randPc();
        logic [31:0] tagPart;
        case ($urandom_range(0, 3))
            0:       tagPart = 32'd0;
            1:       tagPart = 32'd1;
            2:       tagPart = 32'd2;
            default: tagPart = 32'h03FF_FFFF;
        endcase
        return (tagPart << 6) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
    endfunction

    function automatic logic [31:0] randTarget();
        case ($urandom_range(0, 3))
            0:       return 32'h0000_0100;
            1:       return 32'h0000_0200;
            2:       return 32'h0000_0300;
            default: return $urandom;
        endcase
    endfunction

    // -------------------------------------------------------------------------
    // Main sequence
    // -------------------------------------------------------------------------
    initial begin
        bit          pHit, pTaken;
        logic [31:0] pNext, rPc, rTgt;
        bit          rTk;

        assertCount     = 0;
        failCount       = 0;
        startin         = 1'b1;
        lk_pc           = 32'h40;
        upd_valid       = 1'b0;
        upd_pc          = 32'h0;
        upd_taken       = 1'b0;
        upd_target      = 32'h0;
        upd_pred_taken  = 1'b0;
        upd_pred_target = 32'h0;
        flush_all       = 1'b0;
        modelReset();
        #13;
        startin = 1'b0;

        // Reset state
        applyStimulus(32'h40, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
        checkOutput("reset_next_pc", lk_next_pc, 32'h44);
        checkOutput("reset_branches", 32'(stat_branches), 32'd0);

        // Allocate 0x40 -> 0x100 with a not-taken prediction
        applyStimulus(32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44, 0);
        checkOutput("alloc_hit", 32'(lk_hit), 32'd1);
        checkOutput("alloc_next_pc", lk_next_pc, 32'h100);
        checkOutput("alloc_mispred", 32'(stat_mispred), 32'd1);

        // Train down to strongly not-taken, then one taken step back up
        repeat (3) applyStimulus(32'h40, 1, 32'h40, 0, 32'h100, 1, 32'h100, 0);
        checkOutput("sat0_hit", 32'(lk_hit), 32'd1);
        checkOutput("sat0_next_pc", lk_next_pc, 32'h44);
        applyStimulus(32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44, 0);
        checkOutput("ctr01_taken", 32'(lk_taken), 32'd0);

        // Alias 0x80 evicts 0x40
        applyStimulus(32'h80, 1, 32'h80, 1, 32'h200, 0, 32'h84, 0);
        checkOutput("alias_next_pc", lk_next_pc, 32'h200);
        applyStimulus(32'h40, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
        checkOutput("alias_evicted", 32'(lk_hit), 32'd0);

        // Same-cycle lookup and allocation: old state this cycle, new next
        applyStimulus(32'h40, 1, 32'h40, 1, 32'h140, 0, 32'h44, 0);
        checkOutput("read_old_then_new", 32'(lk_hit), 32'd1);

        // Flush beats a coincident update but the update is still counted
        applyStimulus(32'h40, 1, 32'h80, 1, 32'h200, 0, 32'h84, 1);
        checkOutput("flush_hit", 32'(lk_hit), 32'd0);
        checkOutput("flush_branches", 32'(stat_branches), 32'd8);
        applyStimulus(32'h80, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);

        // Wrap of fall-through at the top of the address space
        applyStimulus(32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0, 0);

        // Twenty mispredicting updates saturate the 4-bit statistics
        repeat (20) applyStimulus(32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44, 0);
        checkOutput("small_sat_branches", 32'(s_stat_branches), 32'd15);
        checkOutput("small_sat_mispred", 32'(s_stat_mispred), 32'd15);

        // Asynchronous reset between edges, with an update in flight
        @(negedge clk);
        lk_pc = 32'h40; upd_valid = 1; upd_pc = 32'h80; upd_taken = 1;
        upd_target = 32'h200; upd_pred_taken = 0; upd_pred_target = 32'h84; flush_all = 0;
        #1;
        checkOutput("pre_reset_hit", 32'(lk_hit), 32'd1);
        startin = 1'b1;
        #1;
        checkOutput("async_hit", 32'(lk_hit), 32'd0);
        checkOutput("async_taken", 32'(lk_taken), 32'd0);
        checkOutput("async_next_pc", lk_next_pc, 32'h44);
        checkOutput("async_branches", 32'(stat_branches), 32'd0);
        checkOutput("async_mispred", 32'(stat_mispred), 32'd0);
        checkOutput("async_small_branches", 32'(s_stat_branches), 32'd0);
        modelReset();
        @(posedge clk);
        #1;
        checkOutput("reset_held_branches", 32'(stat_branches), 32'd0);
        @(negedge clk);
        upd_valid = 1'b0;
        #1;
        startin = 1'b0;
        applyStimulus(32'h80, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            rPc  = randPc();
            rTk  = ($urandom_range(0, 1) == 1);
            rTgt = randTarget();
            modelLookup(rPc, pHit, pTaken, pNext);
            if ($urandom_range(0, 3) == 0) begin
                pTaken = ($urandom_range(0, 1) == 1);
                pNext  = randTarget();
            end
            applyStimulus(($urandom_range(0, 1) == 1) ? rPc : randPc(),
                          ($urandom_range(0, 4) != 0), rPc, rTk, rTgt,
                          pTaken, pNext, ($urandom_range(0, 49) == 0));
        end
        applyStimulus(32'h40, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor with a direct-mapped branch target buffer (BTB) and per-entry saturating direction counters.
- IF stage looks up the current PC combinationally and receives a predicted next PC.
- MEM stage returns the resolved branch outcome. The block trains its state and flags mispredictions so the pipeline can flush and redirect.
- Replaces the fixed "always fall through, branch resolved in MEM" policy of the 5-stage core.

Parameters:
- ADDR_W, 32, PC/target width in bits.
- ENTRIES, 16, number of BTB entries; power of 2, at least 2. IDX_W = log2(ENTRIES).
- CTR_W, 2, direction counter width in bits, at least 1.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  rising-edge clock.
- startin  in  1  asynchronous active-high reset.
- lk_pc  in  ADDR_W  IF-stage PC to predict.
- lk_hit  out  1  tag match on a valid entry.
- lk_taken  out  1  predicted taken.
- lk_next_pc  out  ADDR_W  predicted next PC.
- upd_valid  in  1  resolved branch presented this cycle.
- upd_pc  in  ADDR_W  PC of the resolved branch.
- upd_taken  in  1  actual direction.
- upd_target  in  ADDR_W  actual taken target.
- upd_pred_taken  in  1  direction that was predicted for this branch (carried down the pipe).
- upd_pred_target  in  ADDR_W  next PC that was predicted for this branch.
- upd_mispredict  out  1  combinational misprediction flag.
- upd_redirect_pc  out  ADDR_W  correct next PC.
- flush_all  in  1  synchronous invalidate of all entries.
- stat_branches  out  CNT_W  count of resolved branches.
- stat_mispred  out  CNT_W  count of mispredictions.

Behaviour:
- Reset (async, immediate):
  - All valid bits = 0.
  - All counters = weakly not-taken, 2^(CTR_W-1)-1 (01 for CTR_W=2).
  - Both stat counters = 0.
  - Tag and target arrays need no reset.
- Index and tag:
  - idx = pc[IDX_W+1:2].
  - tag = pc[ADDR_W-1:IDX_W+2].
  - pc[1:0] is ignored.
- Lookup (purely combinational, zero latency):
  - lk_hit = valid[idx] and tag match.
  - lk_taken = lk_hit and ctr[idx] MSB.
  - lk_next_pc = lk_taken ? target[idx] : lk_pc+4, truncated to ADDR_W (wraps at top of address space).
- Mispredict (combinational on upd_* inputs, gated by upd_valid):
  - Asserted when upd_pred_taken != upd_taken.
  - Also asserted when both are taken and upd_pred_target != upd_target.
  - upd_redirect_pc = upd_taken ? upd_target : upd_pc+4.
  - When upd_valid=0: upd_mispredict=0 and upd_redirect_pc=upd_pc+4.
- Update (rising edge, when upd_valid=1 and flush_all=0):
  - Hit, taken: ctr increments, saturating at 2^CTR_W-1; target := upd_target.
  - Hit, not taken: ctr decrements, saturating at 0; target unchanged.
  - Miss, taken: allocate the entry, overwriting any alias. valid=1, tag written, target=upd_target, ctr = weakly taken, 2^(CTR_W-1).
  - Miss, not taken: no state change.
- Statistics:
  - stat_branches += 1 on each upd_valid edge.
  - stat_mispred += 1 when upd_mispredict=1.
  - Both saturate at all-ones (no wrap).
  - Both continue counting during flush_all.
- flush_all:
  - Next edge clears all valid bits.
  - Counters and targets are retained but unreachable.
  - Has priority over a coincident update; that update trains nothing but is still counted in stats.
- Same-cycle lookup and update of the same index: lookup returns the pre-update state (read-old). The new state is visible the following cycle.
- Reset asserted mid-operation: lookups immediately return hit=0, taken=0, next_pc=lk_pc+4. Any update in flight is discarded.
- Storage: flop arrays. No memory macros, no read latency.

Test Plan (ENTRIES=16, CTR_W=2, ADDR_W=32):
1. Reset, then lk_pc=0x40 → lk_hit=0, lk_taken=0, lk_next_pc=0x44; both stats=0.
2. Update pc=0x40, taken, target=0x100, pred_taken=0 → upd_mispredict=1, redirect=0x100. Next cycle lookup 0x40 → hit=1, taken=1, next_pc=0x100; stat_mispred=1.
3. Three not-taken updates to 0x40 → ctr 10→01→00→00 (saturates). Lookup 0x40 → hit=1, taken=0, next_pc=0x44. One taken update → 01, still predicted not taken.
4. Alias: after entry 0x40 is allocated, taken update pc=0x80 target=0x200 → lookup 0x40 hit=0; lookup 0x80 → next_pc=0x200.
5. Same-cycle lookup 0x40 and allocating update 0x40 → lookup that cycle shows hit=0, next cycle hit=1. Assert flush_all together with an update → next cycle all hits=0 and stat_branches incremented.
6. Set CNT_W=4, issue 20 mispredicting updates → stat_branches=stat_mispred=15 (saturated). Assert startin asynchronously between edges → outputs return to reset values without waiting for a clock edge.
